// File: rtl/thermal_pkg.sv
// Shared types and constants for the thermal charge controller.
package thermal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FAST     = 3'd1,
    ST_SLOW     = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_FAULT    = 3'd4
  } state_e;

  localparam logic [1:0] RATE_OFF  = 2'b00;
  localparam logic [1:0] RATE_SLOW = 2'b01;
  localparam logic [1:0] RATE_FAST = 2'b10;

  localparam int unsigned DEF_TEMP_W         = 8;
  localparam int unsigned DEF_PCT_W          = 7;
  localparam int unsigned DEF_SLOW_START_PCT = 80;
  localparam int unsigned DEF_T_HOT          = 45;
  localparam int unsigned DEF_T_CRIT         = 60;
  localparam int unsigned DEF_T_HYST         = 3;
  localparam int unsigned DEF_SENSOR_TIMEOUT = 1000;
  localparam int unsigned DEF_FAN_MIN_ON     = 64;

  localparam int unsigned TEMP_RESET = 27;
  localparam int unsigned PCT_FULL   = 100;

  // Charge rate driven in a given state.
  function automatic logic [1:0] rate_of(input state_e s);
    case (s)
      ST_FAST: return RATE_FAST;
      ST_SLOW: return RATE_SLOW;
      default: return RATE_OFF;
    endcase
  endfunction

  // Cool-down release point, clamped at zero so it cannot wrap.
  function automatic int unsigned cool_limit(input int unsigned hot, input int unsigned hyst);
    return (hyst > hot) ? 0 : hot - hyst;
  endfunction

endpackage

// File: rtl/thermal_charge_ctrl_if.sv
// Sensor/charger inputs and controller outputs of thermal_charge_ctrl.
interface thermal_charge_ctrl_if
  import thermal_pkg::*;
#(
  parameter int unsigned TEMP_W = DEF_TEMP_W,
  parameter int unsigned PCT_W  = DEF_PCT_W
);
  logic              charging;
  logic [PCT_W-1:0]  battery_percent;
  logic [TEMP_W-1:0] temp_in;
  logic              temp_valid;
  logic              fault_clr;
  logic [1:0]        rate_mode;
  logic              cooling_fan;
  logic              fault;
  logic              charge_done;
  logic [2:0]        state_o;
  logic [TEMP_W-1:0] temp_peak;

  modport master (
    output charging, battery_percent, temp_in, temp_valid, fault_clr,
    input  rate_mode, cooling_fan, fault, charge_done, state_o, temp_peak
  );

  modport slave (
    input  charging, battery_percent, temp_in, temp_valid, fault_clr,
    output rate_mode, cooling_fan, fault, charge_done, state_o, temp_peak
  );
endinterface

// File: rtl/therm_fan_ctrl.sv
// Cooling fan: hysteresis around T_HOT plus optional minimum on-time.
// Build option THERM_FAN_MIN_ON_EN enables the FAN_MIN_ON hold after each turn-on.
module therm_fan_ctrl
  import thermal_pkg::*;
#(
  parameter int unsigned TEMP_W     = DEF_TEMP_W,
  parameter int unsigned T_HOT      = DEF_T_HOT,
  parameter int unsigned T_HYST     = DEF_T_HYST,
  parameter int unsigned FAN_MIN_ON = DEF_FAN_MIN_ON
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              force_on,
  input  logic [TEMP_W-1:0] temp,
  output logic              fan_o
);
`ifdef THERM_FAN_MIN_ON_EN
  localparam int unsigned MIN_ON_CYC = FAN_MIN_ON;
`else
  localparam int unsigned MIN_ON_CYC = FAN_MIN_ON * 0;
`endif
  localparam int unsigned HOLD_W    = (MIN_ON_CYC > 2) ? $clog2(MIN_ON_CYC) : 1;
  localparam int unsigned HOLD_LOAD = (MIN_ON_CYC > 0) ? MIN_ON_CYC - 1 : 0;

  localparam logic [TEMP_W-1:0] HOT_T  = TEMP_W'(T_HOT);
  localparam logic [TEMP_W-1:0] COOL_T = TEMP_W'(cool_limit(T_HOT, T_HYST));

  logic              dem_d, dem_q;
  logic              fan_d, fan_q;
  logic [HOLD_W-1:0] hold_d, hold_q;

  // Demand with hysteresis: on at/above T_HOT or when forced, off at/below the release point.
  always_comb begin
    dem_d = dem_q;
    if (force_on || (temp >= HOT_T)) dem_d = 1'b1;
    else if (temp <= COOL_T)         dem_d = 1'b0;
  end

  // Fan output and min-on hold counter loaded on each off-to-on edge.
  always_comb begin
    fan_d  = dem_d | (hold_q != '0);
    hold_d = hold_q;
    if (!fan_q && fan_d)   hold_d = HOLD_W'(HOLD_LOAD);
    else if (hold_q != '0) hold_d = hold_q - HOLD_W'(1);
  end

  // Fan state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dem_q  <= 1'b0;
      fan_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      dem_q  <= dem_d;
      fan_q  <= fan_d;
      hold_q <= hold_d;
    end
  end

  assign fan_o = fan_q;

endmodule

// File: rtl/thermal_charge_ctrl.sv
// Thermal-aware battery charge controller: rate selection, fan, fault handling.
// Build option THERM_FAN_MIN_ON_EN adds a minimum fan on-time (see therm_fan_ctrl).
module thermal_charge_ctrl
  import thermal_pkg::*;
#(
  parameter int unsigned TEMP_W         = DEF_TEMP_W,
  parameter int unsigned PCT_W          = DEF_PCT_W,
  parameter int unsigned SLOW_START_PCT = DEF_SLOW_START_PCT,
  parameter int unsigned T_HOT          = DEF_T_HOT,
  parameter int unsigned T_CRIT         = DEF_T_CRIT,
  parameter int unsigned T_HYST         = DEF_T_HYST,
  parameter int unsigned SENSOR_TIMEOUT = DEF_SENSOR_TIMEOUT,
  parameter int unsigned FAN_MIN_ON     = DEF_FAN_MIN_ON
) (
  input logic                  clk,
  input logic                  reset,
  thermal_charge_ctrl_if.slave bus
);
  localparam int unsigned TMO_W = $clog2(SENSOR_TIMEOUT + 1);

  localparam logic [TEMP_W-1:0] HOT_T     = TEMP_W'(T_HOT);
  localparam logic [TEMP_W-1:0] CRIT_T    = TEMP_W'(T_CRIT);
  localparam logic [TEMP_W-1:0] COOL_T    = TEMP_W'(cool_limit(T_HOT, T_HYST));
  localparam logic [TEMP_W-1:0] TEMP_INIT = TEMP_W'(TEMP_RESET);
  localparam logic [PCT_W-1:0]  SLOW_P    = PCT_W'(SLOW_START_PCT);
  localparam logic [PCT_W-1:0]  FULL_P    = PCT_W'(PCT_FULL);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(SENSOR_TIMEOUT);

  state_e            state_d, state_q;
  logic [TEMP_W-1:0] temp_d, temp_q;
  logic [TEMP_W-1:0] peak_d, peak_q;
  logic [TMO_W-1:0]  tmo_d, tmo_q;
  logic              seen_d, seen_q;
  logic              done_d, done_q;
  logic              fault_d, fault_q;
  logic [1:0]        rate_d, rate_q;
  logic              hot_c, crit_c, cool_c, tmo_hit_c, fan_force_c;
  logic              fan_on;

  // Sensor datapath: latched sample, peak tracker, silence counter.
  always_comb begin
    temp_d = temp_q;
    peak_d = peak_q;
    tmo_d  = tmo_q;
    if (bus.temp_valid) temp_d = bus.temp_in;
    if (bus.temp_valid && (bus.temp_in > peak_q)) peak_d = bus.temp_in;
    if (!bus.charging || bus.temp_valid) tmo_d = '0;
    else if (tmo_q != TMO_MAX)           tmo_d = tmo_q + TMO_W'(1);
  end

  assign hot_c     = (temp_q >= HOT_T);
  assign crit_c    = (temp_q >= CRIT_T);
  assign cool_c    = (temp_q <= COOL_T);
  assign tmo_hit_c = (tmo_d == TMO_MAX);

  // A sample counts toward fault release only if it arrives while already in FAULT.
  assign seen_d = (state_q == ST_FAULT) && (seen_q || bus.temp_valid);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: fault entry first, then charger removal, then per-state rules.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_FAULT) begin
      if (bus.fault_clr && cool_c && seen_q) state_d = ST_IDLE;
    end else if (crit_c || tmo_hit_c) begin
      state_d = ST_FAULT;
    end else if (!bus.charging) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hot_c)                               state_d = ST_COOLDOWN;
          else if (bus.battery_percent < SLOW_P)   state_d = ST_FAST;
          else if (bus.battery_percent < FULL_P)   state_d = ST_SLOW;
        end
        ST_FAST: begin
          if (hot_c)                               state_d = ST_COOLDOWN;
          else if (bus.battery_percent >= SLOW_P)  state_d = ST_SLOW;
        end
        ST_SLOW: begin
          if (hot_c)                               state_d = ST_COOLDOWN;
          else if (bus.battery_percent >= FULL_P)  state_d = ST_IDLE;
        end
        ST_COOLDOWN: begin
          if (cool_c) state_d = (bus.battery_percent < SLOW_P) ? ST_FAST : ST_SLOW;
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Output decode from the next state so outputs land with the state change.
  always_comb begin
    rate_d      = rate_of(state_d);
    fault_d     = (state_d == ST_FAULT);
    fan_force_c = (state_d == ST_COOLDOWN) || (state_d == ST_FAULT);
    done_d      = done_q;
    if (!bus.charging || (bus.battery_percent < FULL_P))  done_d = 1'b0;
    else if ((state_q == ST_SLOW) && (state_d == ST_IDLE)) done_d = 1'b1;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      temp_q  <= TEMP_INIT;
      peak_q  <= '0;
      tmo_q   <= '0;
      seen_q  <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      rate_q  <= RATE_OFF;
    end else begin
      temp_q  <= temp_d;
      peak_q  <= peak_d;
      tmo_q   <= tmo_d;
      seen_q  <= seen_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      rate_q  <= rate_d;
    end
  end

  therm_fan_ctrl #(
    .TEMP_W     (TEMP_W),
    .T_HOT      (T_HOT),
    .T_HYST     (T_HYST),
    .FAN_MIN_ON (FAN_MIN_ON)
  ) u_fan (
    .clk      (clk),
    .reset    (reset),
    .force_on (fan_force_c),
    .temp     (temp_q),
    .fan_o    (fan_on)
  );

  assign bus.rate_mode   = rate_q;
  assign bus.cooling_fan = fan_on;
  assign bus.fault       = fault_q;
  assign bus.charge_done = done_q;
  assign bus.state_o     = state_q;
  assign bus.temp_peak   = peak_q;

endmodule
